// File: rtl/cnn_phase_sequencer_if.sv
// Control bundle between the CNN phase sequencer and the solver top level.
// slave = the sequencer itself, master = whatever drives go/abort/fin/sp_en.
interface cnn_phase_sequencer_if #(
   parameter int NUM_PH = 5,
   parameter int DRV_W  = 3
);
   logic              i_go;
   logic              i_abort;
   logic [NUM_PH-1:0] i_fin;
   logic [NUM_PH-1:0] i_sp_en;
   logic [NUM_PH-1:0] o_phase_en;
   logic [DRV_W-1:0]  o_driver;
   logic              o_reset_slave;
   logic              o_busy;
   logic              o_done;
   logic              o_timeout;

   modport master (
      output i_go, i_abort, i_fin, i_sp_en,
      input  o_phase_en, o_driver, o_reset_slave, o_busy, o_done, o_timeout
   );

   modport slave (
      input  i_go, i_abort, i_fin, i_sp_en,
      output o_phase_en, o_driver, o_reset_slave, o_busy, o_done, o_timeout
   );
endinterface

// File: rtl/cnn_phase_sequencer.sv
// Moore master FSM: runs NUM_QUAD step-1 engines then step 2, each phase with READ/WAIT/WRITE write-backs.
// Optional READ-stall watchdog enabled by defining CNN_SEQ_WATCHDOG_EN.
//
// state     | meaning
// S_IDLE    | children held in reset, waiting for go
// S_READ    | engine p enabled, watching fin[p] / sp_en[p]
// S_WAIT    | scratchpad write-back settle, WAIT_CYCLES long
// S_WRITE   | one-cycle scratchpad write, then back to READ(p)
// S_DONE    | one-cycle completion pulse
// S_TIMEOUT | one-cycle watchdog pulse (watchdog build only)
module cnn_phase_sequencer #(
   parameter int NUM_QUAD       = 4,
   parameter int DRV_W          = 3,
   parameter int WAIT_CYCLES    = 1,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input logic                  clk,
   input logic                  reset,
   cnn_phase_sequencer_if.slave bus
);
   localparam int NUM_PH = NUM_QUAD + 1;
   localparam int PH_W   = (NUM_PH > 1) ? $clog2(NUM_PH) : 1;
   localparam int WC_W   = $clog2(WAIT_CYCLES + 1);
   localparam logic [PH_W-1:0] P_LAST  = PH_W'(NUM_PH - 1);
   localparam logic [WC_W-1:0] WC_LOAD = WC_W'(WAIT_CYCLES - 1);

   if (((1 << DRV_W) - 1) <= NUM_QUAD || WAIT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("cnn_phase_sequencer: illegal parameter combination");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_READ, S_WAIT, S_WRITE, S_DONE, S_TIMEOUT
   } state_t;

   state_t          r_state, w_state_next;
   logic [PH_W-1:0] r_p, w_p_next;
   logic [WC_W-1:0] r_wcnt, w_wcnt_next;
   logic            w_fin_p, w_sp_p, w_wd_expired;

   assign w_fin_p = bus.i_fin[r_p];
   assign w_sp_p  = bus.i_sp_en[r_p];

`ifdef CNN_SEQ_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   logic [WD_W-1:0] r_wd;

   // Counts consecutive quiet READ cycles; any exit from READ or any event clears it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_wd <= '0;
      else if (r_state == S_READ && w_state_next == S_READ && !w_fin_p && !w_sp_p)
         r_wd <= r_wd + WD_W'(1);
      else
         r_wd <= '0;
   end

   assign w_wd_expired = (r_wd == WD_LAST);
`else
   assign w_wd_expired = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_p     <= '0;
         r_wcnt  <= '0;
      end else begin
         r_state <= w_state_next;
         r_p     <= w_p_next;
         r_wcnt  <= w_wcnt_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_p_next     = r_p;
      w_wcnt_next  = r_wcnt;
      case (r_state)
         S_IDLE: begin
            w_p_next = '0;
            if (bus.i_go) w_state_next = S_READ;
         end
         S_READ: begin
            if (bus.i_abort) begin
               w_state_next = S_IDLE;
            end else if (w_fin_p) begin
               if (r_p == P_LAST) w_state_next = S_DONE;
               else               w_p_next     = r_p + PH_W'(1);
            end else if (w_sp_p) begin
               w_state_next = S_WAIT;
               w_wcnt_next  = WC_LOAD;
            end else if (w_wd_expired) begin
               w_state_next = S_TIMEOUT;
            end
         end
         S_WAIT: begin
            if (bus.i_abort)        w_state_next = S_IDLE;
            else if (r_wcnt == '0)  w_state_next = S_WRITE;
            else                    w_wcnt_next  = r_wcnt - WC_W'(1);
         end
         S_WRITE:   w_state_next = bus.i_abort ? S_IDLE : S_READ;
         S_DONE:    w_state_next = S_IDLE;
         S_TIMEOUT: w_state_next = S_IDLE;
         default:   w_state_next = S_IDLE;
      endcase
   end

   logic [NUM_PH-1:0] w_phase_en;
   logic [DRV_W-1:0]  w_driver;
   logic              w_reset_slave, w_busy, w_done, w_timeout;

   always_comb begin
      w_phase_en    = '0;
      w_driver      = '1;
      w_reset_slave = 1'b0;
      w_busy        = 1'b1;
      w_done        = 1'b0;
      w_timeout     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_reset_slave = 1'b1;
            w_busy        = 1'b0;
         end
         S_READ: begin
            w_phase_en = NUM_PH'(1) << r_p;
            w_driver   = DRV_W'(r_p);
         end
         S_WAIT, S_WRITE: w_driver = DRV_W'(r_p);
         S_DONE:          w_done   = 1'b1;
`ifdef CNN_SEQ_WATCHDOG_EN
         S_TIMEOUT:       w_timeout = 1'b1;
`endif
         default: ;
      endcase
   end

   assign bus.o_phase_en    = w_phase_en;
   assign bus.o_driver      = w_driver;
   assign bus.o_reset_slave = w_reset_slave;
   assign bus.o_busy        = w_busy;
   assign bus.o_done        = w_done;
   assign bus.o_timeout     = w_timeout;
endmodule

// File: tb/tb_cnn_phase_sequencer.sv
// Directed bench for cnn_phase_sequencer: one DUT with WAIT_CYCLES=1, one with WAIT_CYCLES=3.
// Output vector layout: {phase_en[4:0], driver[2:0], reset_slave, busy, done, timeout}.
module tb_cnn_phase_sequencer;
   logic clk;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   cnn_phase_sequencer_if #(.NUM_PH(5), .DRV_W(3)) a ();
   cnn_phase_sequencer_if #(.NUM_PH(5), .DRV_W(3)) b ();

   cnn_phase_sequencer #(.NUM_QUAD(4), .DRV_W(3), .WAIT_CYCLES(1), .TIMEOUT_CYCLES(8)) u_dut (
      .clk(clk), .reset(reset), .bus(a)
   );
   cnn_phase_sequencer #(.NUM_QUAD(4), .DRV_W(3), .WAIT_CYCLES(3), .TIMEOUT_CYCLES(8)) u_dut3 (
      .clk(clk), .reset(reset), .bus(b)
   );

   logic [11:0] obs_a, obs_b;
   assign obs_a = {a.o_phase_en, a.o_driver, a.o_reset_slave, a.o_busy, a.o_done, a.o_timeout};
   assign obs_b = {b.o_phase_en, b.o_driver, b.o_reset_slave, b.o_busy, b.o_done, b.o_timeout};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [11:0] V_IDLE = {5'b00000, 3'b111, 4'b1000};
   localparam logic [11:0] V_DONE = {5'b00000, 3'b111, 4'b0110};
   localparam logic [11:0] V_TOUT = {5'b00000, 3'b111, 4'b0101};

   function automatic logic [11:0] f_read(input int p);
      logic [4:0] one;
      one = 5'b00001 << p;
      return {one, 3'(p), 4'b0100};
   endfunction

   function automatic logic [11:0] f_wr(input int p);
      return {5'b00000, 3'(p), 4'b0100};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      a.i_go = 1'b0; a.i_abort = 1'b0; a.i_fin = '0; a.i_sp_en = '0;
      b.i_go = 1'b0; b.i_abort = 1'b0; b.i_fin = '0; b.i_sp_en = '0;
      step(); step();
      checks++;
      if (obs_a !== V_IDLE) begin errors++; $display("FAIL reset_a got=%b exp=%b", obs_a, V_IDLE); end
      checks++;
      if (obs_b !== V_IDLE) begin errors++; $display("FAIL reset_b got=%b exp=%b", obs_b, V_IDLE); end
      a.i_go = 1'b1;
      step();
      checks++;
      if (obs_a !== V_IDLE) begin errors++; $display("FAIL reset_go_held got=%b exp=%b", obs_a, V_IDLE); end
      a.i_go = 1'b0;
      reset = 1'b0;
      step();
      checks++;
      if (obs_a !== V_IDLE) begin errors++; $display("FAIL reset_release got=%b exp=%b", obs_a, V_IDLE); end
   endtask

   task automatic test_nominal();
      a.i_go = 1'b1;
      for (int p = 0; p < 5; p++) begin
         step();
         a.i_go = 1'b0;
         checks++;
         if (obs_a !== f_read(p)) begin errors++; $display("FAIL nominal_read p=%0d got=%b exp=%b", p, obs_a, f_read(p)); end
         a.i_fin = 5'(1 << p);
      end
      step();
      a.i_fin = '0;
      checks++;
      if (obs_a !== V_DONE) begin errors++; $display("FAIL nominal_done got=%b exp=%b", obs_a, V_DONE); end
      step();
      checks++;
      if (obs_a !== V_IDLE) begin errors++; $display("FAIL nominal_idle got=%b exp=%b", obs_a, V_IDLE); end
   endtask

   task automatic test_writeback();
      a.i_go = 1'b1;
      step();
      a.i_go = 1'b0;
      a.i_fin = 5'b00001;
      step();
      a.i_fin = '0;
      checks++;
      if (obs_a !== f_read(1)) begin errors++; $display("FAIL wb_enter got=%b exp=%b", obs_a, f_read(1)); end
      for (int k = 0; k < 2; k++) begin
         a.i_sp_en = 5'b00010;
         step();
         a.i_sp_en = '0;
         checks++;
         if (obs_a !== f_wr(1)) begin errors++; $display("FAIL wb_wait k=%0d got=%b exp=%b", k, obs_a, f_wr(1)); end
         step();
         checks++;
         if (obs_a !== f_wr(1)) begin errors++; $display("FAIL wb_write k=%0d got=%b exp=%b", k, obs_a, f_wr(1)); end
         step();
         checks++;
         if (obs_a !== f_read(1)) begin errors++; $display("FAIL wb_read k=%0d got=%b exp=%b", k, obs_a, f_read(1)); end
      end
      a.i_fin = 5'b00010;
      step();
      a.i_fin = '0;
      checks++;
      if (obs_a !== f_read(2)) begin errors++; $display("FAIL wb_exit got=%b exp=%b", obs_a, f_read(2)); end
      a.i_abort = 1'b1;
      step();
      a.i_abort = 1'b0;
   endtask

   task automatic test_masking();
      a.i_go = 1'b1;
      step();
      a.i_go = 1'b0;
      a.i_fin = 5'b00001;
      step();
      a.i_fin = 5'b00010;
      step();
      a.i_fin = 5'b00001;
      a.i_sp_en = 5'b10001;
      step();
      checks++;
      if (obs_a !== f_read(2)) begin errors++; $display("FAIL mask_stray got=%b exp=%b", obs_a, f_read(2)); end
      a.i_fin = 5'b00100;
      a.i_sp_en = 5'b00100;
      step();
      a.i_fin = '0;
      a.i_sp_en = '0;
      checks++;
      if (obs_a !== f_read(3)) begin errors++; $display("FAIL fin_over_sp got=%b exp=%b", obs_a, f_read(3)); end
      step();
      checks++;
      if (obs_a !== f_read(3)) begin errors++; $display("FAIL fin_over_sp_hold got=%b exp=%b", obs_a, f_read(3)); end
      a.i_abort = 1'b1;
      step();
      a.i_abort = 1'b0;
   endtask

   task automatic test_abort();
      a.i_go = 1'b1;
      step();
      a.i_go = 1'b0;
      for (int p = 0; p < 3; p++) begin
         a.i_fin = 5'(1 << p);
         step();
      end
      a.i_fin = '0;
      a.i_sp_en = 5'b01000;
      step();
      a.i_sp_en = '0;
      checks++;
      if (obs_a !== f_wr(3)) begin errors++; $display("FAIL abort_pre_wait got=%b exp=%b", obs_a, f_wr(3)); end
      a.i_abort = 1'b1;
      step();
      a.i_abort = 1'b0;
      checks++;
      if (obs_a !== V_IDLE) begin errors++; $display("FAIL abort_wait got=%b exp=%b", obs_a, V_IDLE); end
      step();
      checks++;
      if (obs_a !== V_IDLE) begin errors++; $display("FAIL abort_no_done got=%b exp=%b", obs_a, V_IDLE); end
      a.i_abort = 1'b1;
      a.i_go = 1'b1;
      step();
      a.i_go = 1'b0;
      checks++;
      if (obs_a !== f_read(0)) begin errors++; $display("FAIL abort_in_idle got=%b exp=%b", obs_a, f_read(0)); end
      step();
      a.i_abort = 1'b0;
      checks++;
      if (obs_a !== V_IDLE) begin errors++; $display("FAIL abort_read got=%b exp=%b", obs_a, V_IDLE); end
   endtask

   task automatic test_reset_mid();
      a.i_go = 1'b1;
      step();
      a.i_go = 1'b0;
      a.i_fin = 5'b00001;
      step();
      a.i_fin = '0;
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (obs_a !== V_IDLE) begin errors++; $display("FAIL reset_mid got=%b exp=%b", obs_a, V_IDLE); end
      #2;
      reset = 1'b0;
      step();
      checks++;
      if (obs_a !== V_IDLE) begin errors++; $display("FAIL reset_mid_after got=%b exp=%b", obs_a, V_IDLE); end
   endtask

   task automatic test_go_held();
      a.i_go = 1'b1;
      for (int p = 0; p < 5; p++) begin
         step();
         a.i_fin = 5'(1 << p);
      end
      step();
      a.i_fin = '0;
      checks++;
      if (obs_a !== V_DONE) begin errors++; $display("FAIL go_held_done got=%b exp=%b", obs_a, V_DONE); end
      step();
      checks++;
      if (obs_a !== V_IDLE) begin errors++; $display("FAIL go_held_idle got=%b exp=%b", obs_a, V_IDLE); end
      step();
      a.i_go = 1'b0;
      checks++;
      if (obs_a !== f_read(0)) begin errors++; $display("FAIL go_held_restart got=%b exp=%b", obs_a, f_read(0)); end
      a.i_abort = 1'b1;
      step();
      a.i_abort = 1'b0;
   endtask

   task automatic test_wait3();
      b.i_go = 1'b1;
      step();
      b.i_go = 1'b0;
      for (int p = 0; p < 4; p++) begin
         b.i_fin = 5'(1 << p);
         step();
      end
      b.i_fin = '0;
      checks++;
      if (obs_b !== f_read(4)) begin errors++; $display("FAIL w3_read4 got=%b exp=%b", obs_b, f_read(4)); end
      b.i_sp_en = 5'b10000;
      for (int k = 0; k < 4; k++) begin
         step();
         b.i_sp_en = '0;
         checks++;
         if (obs_b !== f_wr(4)) begin errors++; $display("FAIL w3_low k=%0d got=%b exp=%b", k, obs_b, f_wr(4)); end
      end
      step();
      checks++;
      if (obs_b !== f_read(4)) begin errors++; $display("FAIL w3_back got=%b exp=%b", obs_b, f_read(4)); end
      b.i_fin = 5'b10000;
      step();
      b.i_fin = '0;
      checks++;
      if (obs_b !== V_DONE) begin errors++; $display("FAIL w3_done got=%b exp=%b", obs_b, V_DONE); end
      step();
      checks++;
      if (obs_b !== V_IDLE) begin errors++; $display("FAIL w3_idle got=%b exp=%b", obs_b, V_IDLE); end
   endtask

   task automatic test_watchdog();
      a.i_go = 1'b1;
      step();
      a.i_go = 1'b0;
`ifdef CNN_SEQ_WATCHDOG_EN
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (obs_a !== f_read(0)) begin errors++; $display("FAIL wd_read k=%0d got=%b exp=%b", k, obs_a, f_read(0)); end
         step();
      end
      checks++;
      if (obs_a !== V_TOUT) begin errors++; $display("FAIL wd_timeout got=%b exp=%b", obs_a, V_TOUT); end
      step();
      checks++;
      if (obs_a !== V_IDLE) begin errors++; $display("FAIL wd_idle got=%b exp=%b", obs_a, V_IDLE); end
`else
      for (int k = 0; k < 20; k++) begin
         checks++;
         if (obs_a !== f_read(0)) begin errors++; $display("FAIL nowd_read k=%0d got=%b exp=%b", k, obs_a, f_read(0)); end
         step();
      end
      a.i_abort = 1'b1;
      step();
      a.i_abort = 1'b0;
      checks++;
      if (obs_a !== V_IDLE) begin errors++; $display("FAIL nowd_abort got=%b exp=%b", obs_a, V_IDLE); end
`endif
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_writeback();
      test_masking();
      test_abort();
      test_reset_mid();
      test_go_held();
      test_wait3();
      test_watchdog();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
